// File: rtl/frame_buf_sched_if.sv
// Control bundle between VSYNC timing, the frame-buffer scheduler and the AXI burst engines.
interface frame_buf_sched_if;
   logic        vs_i;
   logic        wen_i;
   logic        wr_done_i;
   logic [31:0] wr_base_o;
   logic [31:0] rd_base_o;
   logic [1:0]  wr_idx_o;
   logic [1:0]  rd_idx_o;
   logic        wr_active_o;
   logic        rd_valid_o;
   logic        frame_start_o;
   logic [15:0] drop_cnt_o;
   logic [15:0] abort_cnt_o;

   modport master (
      output vs_i, wen_i, wr_done_i,
      input  wr_base_o, rd_base_o, wr_idx_o, rd_idx_o, wr_active_o, rd_valid_o,
             frame_start_o, drop_cnt_o, abort_cnt_o
   );

   modport slave (
      input  vs_i, wen_i, wr_done_i,
      output wr_base_o, rd_base_o, wr_idx_o, rd_idx_o, wr_active_o, rd_valid_o,
             frame_start_o, drop_cnt_o, abort_cnt_o
   );
endinterface

// File: rtl/frame_buf_sched.sv
// Frame-buffer scheduler: on each VSYNC rise commits the written frame, hands the newest
// completed buffer to the reader and allocates the lowest free buffer to the writer.
module frame_buf_sched #(
   parameter int unsigned NBUF     = 3,
   parameter int unsigned H_WIDTH  = 1920,
   parameter int unsigned V_HEIGHT = 1080,
   parameter logic [31:0] BASE     = 32'h2000_0000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   frame_buf_sched_if.slave bus
);
   localparam logic [63:0] SIZE64 = 64'(H_WIDTH) * 64'(V_HEIGHT) * 64'd3;
   localparam logic [31:0] SIZE   = SIZE64[31:0];
   localparam logic [63:0] END64  = 64'(BASE) + 64'(NBUF) * SIZE64;

   if (NBUF < 2 || NBUF > 4) begin : g_bad_nbuf
      $error("frame_buf_sched: NBUF must be in 2..4");
   end
   if (END64 > 64'h1_0000_0000) begin : g_bad_range
      $error("frame_buf_sched: buffers exceed the 32-bit address space");
   end

   typedef enum logic [1:0] {FREE, WRITING, READY, READING} buf_state_t;

   buf_state_t  st   [NBUF];
   buf_state_t  st_n [NBUF];
   logic        vs_q;
   logic        vs_rise;
   logic        wr_cplt;
   logic        wr_cplt_n;
   logic        has_wr;
   logic        has_rdy;
   logic        commit;
   logic        found;
   logic        drop_inc;
   logic        abort_inc;
   logic [1:0]  wr_idx_n;
   logic [1:0]  rd_idx_n;
   logic        wr_active_n;
   logic        rd_valid_n;

   function automatic logic [31:0] base_of(input logic [1:0] idx);
      return BASE + 32'(idx) * SIZE;
   endfunction

   always_comb begin
      vs_rise     = bus.vs_i & ~vs_q;
      st_n        = st;
      wr_cplt_n   = wr_cplt;
      wr_idx_n    = bus.wr_idx_o;
      rd_idx_n    = bus.rd_idx_o;
      wr_active_n = bus.wr_active_o;
      rd_valid_n  = bus.rd_valid_o;
      drop_inc    = 1'b0;
      abort_inc   = 1'b0;
      has_wr      = 1'b0;
      has_rdy     = 1'b0;
      found       = 1'b0;

      for (int unsigned i = 0; i < NBUF; i++) begin
         if (st[i] == WRITING) has_wr = 1'b1;
      end
      // A done pulse coinciding with the VSYNC rise still completes the ending frame.
      commit = has_wr & (wr_cplt | bus.wr_done_i);

      if (!vs_rise) begin
         if (has_wr && bus.wr_done_i) wr_cplt_n = 1'b1;
      end else begin
         wr_cplt_n = 1'b0;
         abort_inc = has_wr & ~commit;
         for (int unsigned i = 0; i < NBUF; i++) begin
            if (st[i] == WRITING) begin
               st_n[i] = commit ? READY : FREE;
            end else if (st[i] == READY && commit) begin
               st_n[i]  = FREE;
               drop_inc = 1'b1;
            end
         end

         for (int unsigned i = 0; i < NBUF; i++) begin
            if (st_n[i] == READY) has_rdy = 1'b1;
         end
         if (has_rdy) begin
            rd_valid_n = 1'b1;
            for (int unsigned i = 0; i < NBUF; i++) begin
               if (st_n[i] == READING) begin
                  st_n[i] = FREE;
               end else if (st_n[i] == READY) begin
                  st_n[i]  = READING;
                  rd_idx_n = 2'(i);
               end
            end
         end

         wr_active_n = 1'b0;
         if (bus.wen_i) begin
            for (int unsigned i = 0; i < NBUF; i++) begin
               if (!found && st_n[i] == FREE) begin
                  found       = 1'b1;
                  st_n[i]     = WRITING;
                  wr_idx_n    = 2'(i);
                  wr_active_n = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vs_q              <= 1'b1;
         wr_cplt           <= 1'b0;
         st                <= '{default: FREE};
         bus.wr_base_o     <= BASE;
         bus.rd_base_o     <= BASE;
         bus.wr_idx_o      <= '0;
         bus.rd_idx_o      <= '0;
         bus.wr_active_o   <= 1'b0;
         bus.rd_valid_o    <= 1'b0;
         bus.frame_start_o <= 1'b0;
         bus.drop_cnt_o    <= '0;
         bus.abort_cnt_o   <= '0;
      end else begin
         vs_q              <= bus.vs_i;
         wr_cplt           <= wr_cplt_n;
         st                <= st_n;
         bus.wr_idx_o      <= wr_idx_n;
         bus.rd_idx_o      <= rd_idx_n;
         bus.wr_base_o     <= base_of(wr_idx_n);
         bus.rd_base_o     <= base_of(rd_idx_n);
         bus.wr_active_o   <= wr_active_n;
         bus.rd_valid_o    <= rd_valid_n;
         bus.frame_start_o <= vs_rise;
         if (drop_inc && bus.drop_cnt_o != '1) bus.drop_cnt_o <= bus.drop_cnt_o + 16'd1;
         if (abort_inc && bus.abort_cnt_o != '1) bus.abort_cnt_o <= bus.abort_cnt_o + 16'd1;
      end
   end
endmodule

// File: tb/tb_frame_buf_sched.sv
// Bench for frame_buf_sched: directed table plus random traffic against a buffer-ownership model,
// run on an NBUF=3 and an NBUF=2 instance in parallel.
module tb_frame_buf_sched;
   localparam logic [31:0] BASE = 32'h2000_0000;
   localparam longint      SIZE = 6220800;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   frame_buf_sched_if bus3();
   frame_buf_sched_if bus2();

   frame_buf_sched #(.NBUF(3), .H_WIDTH(1920), .V_HEIGHT(1080), .BASE(BASE))
      dut3 (.clk_i(clk), .rst_i(rst), .bus(bus3));
   frame_buf_sched #(.NBUF(2), .H_WIDTH(1920), .V_HEIGHT(1080), .BASE(BASE))
      dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

   int total = 0;
   int bad   = 0;

   // Model: which buffer each role owns (-1 = none), plus the visible outputs.
   int nb [2] = '{3, 2};
   int m_vsq [2], m_cplt [2], m_w [2], m_rdy [2], m_r [2];
   int m_wi [2], m_ri [2], m_wa [2], m_rv [2], m_fs [2], m_drop [2], m_abort [2];

   typedef struct {
      logic rst, vs, wen, done;
      int   fs, wi, wa, ri, rv, ab;
   } vec_t;
   vec_t tbl [14];

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input logic r, input logic vs, input logic wen, input logic done);
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            m_vsq[k] = 1; m_cplt[k] = 0; m_w[k] = -1; m_rdy[k] = -1; m_r[k] = -1;
            m_wi[k] = 0; m_ri[k] = 0; m_wa[k] = 0; m_rv[k] = 0; m_fs[k] = 0;
            m_drop[k] = 0; m_abort[k] = 0;
         end else begin
            int  rise;
            int  committed;
            bit  got;
            rise     = (vs && m_vsq[k] == 0) ? 1 : 0;
            m_vsq[k] = vs ? 1 : 0;
            m_fs[k]  = rise;
            if (rise == 0) begin
               if (done && m_w[k] >= 0) m_cplt[k] = 1;
            end else begin
               committed = (m_w[k] >= 0 && (m_cplt[k] == 1 || done)) ? 1 : 0;
               if (m_w[k] >= 0 && committed == 0 && m_abort[k] < 65535) m_abort[k]++;
               if (committed == 1) begin
                  if (m_rdy[k] >= 0 && m_drop[k] < 65535) m_drop[k]++;
                  m_rdy[k] = m_w[k];
               end
               m_w[k] = -1;
               m_cplt[k] = 0;
               if (m_rdy[k] >= 0) begin
                  m_r[k] = m_rdy[k]; m_rdy[k] = -1; m_ri[k] = m_r[k]; m_rv[k] = 1;
               end
               m_wa[k] = 0;
               got = 1'b0;
               if (wen) begin
                  for (int i = 0; i < nb[k]; i++) begin
                     if (!got && i != m_r[k] && i != m_rdy[k]) begin
                        got = 1'b1; m_w[k] = i; m_wi[k] = i; m_wa[k] = 1;
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic cmp_all();
      check("n3 wr_idx", bus3.wr_idx_o, m_wi[0]);
      check("n3 rd_idx", bus3.rd_idx_o, m_ri[0]);
      check("n3 wr_base", bus3.wr_base_o, longint'(BASE) + m_wi[0] * SIZE);
      check("n3 rd_base", bus3.rd_base_o, longint'(BASE) + m_ri[0] * SIZE);
      check("n3 wr_active", bus3.wr_active_o, m_wa[0]);
      check("n3 rd_valid", bus3.rd_valid_o, m_rv[0]);
      check("n3 frame_start", bus3.frame_start_o, m_fs[0]);
      check("n3 drop_cnt", bus3.drop_cnt_o, m_drop[0]);
      check("n3 abort_cnt", bus3.abort_cnt_o, m_abort[0]);
      check("n2 wr_idx", bus2.wr_idx_o, m_wi[1]);
      check("n2 rd_idx", bus2.rd_idx_o, m_ri[1]);
      check("n2 wr_base", bus2.wr_base_o, longint'(BASE) + m_wi[1] * SIZE);
      check("n2 rd_base", bus2.rd_base_o, longint'(BASE) + m_ri[1] * SIZE);
      check("n2 wr_active", bus2.wr_active_o, m_wa[1]);
      check("n2 rd_valid", bus2.rd_valid_o, m_rv[1]);
      check("n2 frame_start", bus2.frame_start_o, m_fs[1]);
      check("n2 drop_cnt", bus2.drop_cnt_o, m_drop[1]);
      check("n2 abort_cnt", bus2.abort_cnt_o, m_abort[1]);
   endtask

   // Drive one cycle of inputs, let the edge happen, then compare both DUTs to the model.
   task automatic step(input logic r, input logic vs, input logic wen, input logic done);
      rst = r;
      bus3.vs_i = vs; bus3.wen_i = wen; bus3.wr_done_i = done;
      bus2.vs_i = vs; bus2.wen_i = wen; bus2.wr_done_i = done;
      @(posedge clk);
      model_update(r, vs, wen, done);
      #1;
      cmp_all();
      @(negedge clk);
   endtask

   initial begin
      int phase;
      int len;

      bus3.vs_i = 1'b0; bus3.wen_i = 1'b0; bus3.wr_done_i = 1'b0;
      bus2.vs_i = 1'b0; bus2.wen_i = 1'b0; bus2.wr_done_i = 1'b0;

      //          rst vs wen done | fs wi wa ri rv ab
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 1, 0, 0, 0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1, 0, 0, 0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1, 0, 0, 0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 1, 0, 1, 0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 1, 0, 1, 0};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 1, 1, 1, 0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1, 1, 1, 0};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 1, 1, 1, 1};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1, 1, 1, 1};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 1, 1};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 1, 1};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 1, 0, 1, 1};

      @(negedge clk);
      for (int v = 0; v < 14; v++) begin
         step(tbl[v].rst, tbl[v].vs, tbl[v].wen, tbl[v].done);
         check($sformatf("tbl%0d frame_start", v), bus3.frame_start_o, tbl[v].fs);
         check($sformatf("tbl%0d wr_idx", v), bus3.wr_idx_o, tbl[v].wi);
         check($sformatf("tbl%0d wr_active", v), bus3.wr_active_o, tbl[v].wa);
         check($sformatf("tbl%0d rd_idx", v), bus3.rd_idx_o, tbl[v].ri);
         check($sformatf("tbl%0d rd_valid", v), bus3.rd_valid_o, tbl[v].rv);
         check($sformatf("tbl%0d abort_cnt", v), bus3.abort_cnt_o, tbl[v].ab);
         check($sformatf("tbl%0d wr_base", v), bus3.wr_base_o, longint'(BASE) + tbl[v].wi * SIZE);
         check($sformatf("tbl%0d rd_base", v), bus3.rd_base_o, longint'(BASE) + tbl[v].ri * SIZE);
         check($sformatf("tbl%0d drop_cnt", v), bus3.drop_cnt_o, 0);
      end

      // NBUF=2: done pulse in the very VSYNC-rise cycle commits buffer 1 rather than aborting it.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("same-cycle frame_start", bus2.frame_start_o, 1);
      check("same-cycle abort_cnt", bus2.abort_cnt_o, 1);
      check("same-cycle rd_idx", bus2.rd_idx_o, 1);
      check("same-cycle rd_valid", bus2.rd_valid_o, 1);
      check("same-cycle wr_idx", bus2.wr_idx_o, 0);

      // Reset mid-frame with VSYNC held high, then no edge until it falls and rises again.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check("rst wr_base", bus3.wr_base_o, longint'(BASE));
      check("rst rd_base", bus3.rd_base_o, longint'(BASE));
      check("rst wr_idx", bus3.wr_idx_o, 0);
      check("rst rd_idx", bus3.rd_idx_o, 0);
      check("rst wr_active", bus3.wr_active_o, 0);
      check("rst rd_valid", bus3.rd_valid_o, 0);
      check("rst frame_start", bus3.frame_start_o, 0);
      check("rst drop_cnt", bus3.drop_cnt_o, 0);
      check("rst abort_cnt", bus3.abort_cnt_o, 0);
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0);
         check("held vs frame_start", bus3.frame_start_o, 0);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("re-rise frame_start", bus3.frame_start_o, 1);
      check("re-rise wr_active", bus3.wr_active_o, 1);
      check("re-rise wr_idx", bus3.wr_idx_o, 0);
      check("re-rise rd_valid", bus3.rd_valid_o, 0);

      // Random frames of varying length, occasional resets, against the model.
      phase = 0;
      len   = 8;
      for (int c = 0; c < 1500; c++) begin
         logic r;
         r = ($urandom_range(0, 299) == 0);
         step(r, (phase < 3), ($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0));
         phase++;
         if (phase >= len) begin
            phase = 0;
            len   = $urandom_range(5, 24);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
